// File: rtl/fir_pkg.sv
// fir_pkg: sample types, saturation limits and the round/saturate helper for the FIR output stage
package fir_pkg;
    localparam int IN_W    = 32;
    localparam int OUT_W   = 16;
    localparam int SAT_MAX = 2**(OUT_W-1) - 1;
    localparam int SAT_MIN = -(2**(OUT_W-1));
    typedef logic signed [IN_W-1:0]  sample_in_t;
    typedef logic signed [OUT_W-1:0] sample_out_t;
    function automatic sample_out_t sat_round(input sample_in_t x, input int shift);
        logic signed [IN_W:0] half;
        logic signed [IN_W:0] w;
        half = '0;
        if (shift > 0) half[shift-1] = 1'b1;
        w = ($signed({x[IN_W-1], x}) + half) >>> shift;
        if (w > (IN_W+1)'(SAT_MAX)) return sample_out_t'(SAT_MAX);
        if (w < (IN_W+1)'(SAT_MIN)) return sample_out_t'(SAT_MIN);
        return sample_out_t'(w);
    endfunction
endpackage

// File: rtl/fir_out_packer_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push at full succeeds only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr    = push && (!full || pop);
    assign rd    = pop && !empty;
    assign dout  = empty ? '0 : mem[rp];
    // storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end
    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            count <= count + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/fir_out_packer.sv
// fir_out_packer: rescale/round/saturate FIR samples, pack them into beats and stream them out
module fir_out_packer #(
    parameter int IN_W        = 32,
    parameter int OUT_W       = 16,
    parameter int SHIFT       = 0,
    parameter int PACK        = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tvalid,
    input  logic [IN_W-1:0]               s_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [PACK*OUT_W-1:0]         m_tdata,
    output logic                          m_tlast,
    input  logic                          clear_ovf,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);
    import fir_pkg::*;
    localparam int BW = PACK*OUT_W;
    localparam int IW = $clog2(PACK+1);
    localparam int FW = $clog2(FRAME_BEATS+1);
    logic s1_valid;
    sample_out_t s1_data;
    logic [BW-1:0] pack;
    logic [IW-1:0] idx;
    logic beat_rdy;
    logic [FW-1:0] frame;
    logic full, empty, pop, drop, accept, tlast;
    assign m_tvalid = !empty;
    assign pop      = m_tvalid && m_tready;
    assign accept   = beat_rdy && (!full || pop);
    assign drop     = beat_rdy && full && !pop;
    assign tlast    = frame == FW'(FRAME_BEATS-1);
    // stage 1: round and saturate each incoming sample
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= s_tvalid;
            if (s_tvalid) s1_data <= sat_round(s_tdata, SHIFT);
        end
    end
    // stage 2: drop samples into slots, flag a full beat for the FIFO on the following edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pack     <= '0;
            idx      <= '0;
            beat_rdy <= 1'b0;
        end else begin
            beat_rdy <= s1_valid && idx == IW'(PACK-1);
            if (s1_valid) begin
                pack[idx*OUT_W +: OUT_W] <= s1_data;
                idx <= idx == IW'(PACK-1) ? '0 : idx + 1'b1;
            end
        end
    end
    // frame position advances only on beats actually stored
    always_ff @(posedge clk) begin
        if (rst) frame <= '0;
        else if (accept) frame <= tlast ? '0 : frame + 1'b1;
    end
    // overflow status; a drop in the same cycle as clear_ovf takes priority
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            drop_cnt <= clear_ovf ? 16'd1 : (drop_cnt == 16'hFFFF ? drop_cnt : drop_cnt + 16'd1);
        end else if (clear_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end
    sync_fifo #(.WIDTH(BW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (beat_rdy),
        .din   ({tlast, pack}),
        .pop   (pop),
        .dout  ({m_tlast, m_tdata}),
        .full  (full),
        .empty (empty),
        .count (fill)
    );
endmodule

// File: tb/tb_fir_out_packer.sv
// tb_fir_out_packer: directed scoreboard bench for fir_out_packer
module tb_fir_out_packer;
    logic clk = 1'b0, rst = 1'b1;
    logic s_tvalid = 1'b0, m_tready = 1'b0, clear_ovf = 1'b0;
    logic [31:0] s_tdata = '0;
    logic m_tvalid, m_tlast, overflow;
    logic [63:0] m_tdata;
    logic [15:0] drop_cnt;
    logic [4:0] fill;
    logic b_s_tvalid = 1'b0, b_m_tready = 1'b0, b_clear_ovf = 1'b0;
    logic [31:0] b_s_tdata = '0;
    logic b_m_tvalid, b_m_tlast, b_overflow;
    logic [63:0] b_m_tdata;
    logic [15:0] b_drop_cnt;
    logic [4:0] b_fill;
    int checks = 0, errors = 0;
    logic [63:0] mdl_beat = '0;
    int mdl_idx = 0, mdl_frame = 0, mdl_fill = 0, mdl_drops = 0;
    logic [64:0] q[$];

    always #5 clk = ~clk;

    fir_out_packer dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .clear_ovf(clear_ovf), .overflow(overflow), .drop_cnt(drop_cnt), .fill(fill)
    );

    fir_out_packer #(.SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .s_tvalid(b_s_tvalid), .s_tdata(b_s_tdata),
        .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata), .m_tlast(b_m_tlast),
        .clear_ovf(b_clear_ovf), .overflow(b_overflow), .drop_cnt(b_drop_cnt), .fill(b_fill)
    );

    function automatic logic [15:0] model_sample(input longint x, input int shift);
        longint r;
        r = shift > 0 ? (x + (longint'(1) << (shift-1))) >>> shift : x;
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int x);
        s_tvalid = 1'b1;
        s_tdata  = x;
        mdl_beat[mdl_idx*16 +: 16] = model_sample(x, 0);
        mdl_idx++;
        if (mdl_idx == 4) begin
            mdl_idx = 0;
            if (mdl_fill >= 16) mdl_drops++;
            else begin
                q.push_back({mdl_frame == 3, mdl_beat});
                mdl_fill++;
                mdl_frame = (mdl_frame + 1) % 4;
            end
        end
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic send_b(input int x);
        b_s_tvalid = 1'b1;
        b_s_tdata  = x;
        tick();
        b_s_tvalid = 1'b0;
    endtask

    task automatic front_check(input string tag);
        int n = 0;
        while (!m_tvalid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 65'(m_tvalid), 65'd1);
        chk(tag, {m_tlast, m_tdata}, q.size() > 0 ? q.pop_front() : 65'h0);
        mdl_fill--;
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            front_check(tag);
            m_tready = 1'b1;
            tick();
            m_tready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_idx = 0;
        mdl_frame = 0;
        mdl_fill = 0;
        mdl_drops = 0;
        q.delete();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_tvalid", 65'(m_tvalid), 65'd0);
        chk("rst_tdata", 65'(m_tdata), 65'd0);
        chk("rst_tlast", 65'(m_tlast), 65'd0);
        chk("rst_overflow", 65'(overflow), 65'd0);
        chk("rst_drop_cnt", 65'(drop_cnt), 65'd0);
        chk("rst_fill", 65'(fill), 65'd0);
        rst = 1'b0;
        // saturation and latency
        send(40000);
        send(-40000);
        send(100);
        send(-1);
        tick();
        chk("lat_e1_low", 65'(m_tvalid), 65'd0);
        tick();
        chk("lat_e2_high", 65'(m_tvalid), 65'd1);
        chk("sat_const", 65'(m_tdata), 65'h0_FFFF_0064_8000_7FFF);
        drain(1, "sat_beat");
        // impulse
        send(32767);
        for (int i = 0; i < 7; i++) send(0);
        drain(2, "impulse");
        // rounding on the SHIFT=1 instance
        send_b(3);
        send_b(-3);
        send_b(1);
        send_b(-1);
        tick();
        tick();
        chk("round_valid", 65'(b_m_tvalid), 65'd1);
        chk("round_data", 65'(b_m_tdata), 65'h0_0000_0001_FFFF_0002);
        chk("round_slot1_model", 65'(b_m_tdata[31:16]), 65'(model_sample(-3, 1)));
        // overflow with a stalled consumer
        for (int b = 0; b < 17; b++)
            for (int s = 0; s < 4; s++) send(b * 4 + s + 1);
        tick();
        tick();
        tick();
        chk("ovf_fill", 65'(fill), 65'd16);
        chk("ovf_flag", 65'(overflow), 65'd1);
        chk("ovf_drop_cnt", 65'(drop_cnt), 65'(mdl_drops));
        for (int i = 0; i < 3; i++) begin
            chk("stall_stable", {m_tlast, m_tdata}, q[0]);
            tick();
        end
        // push and pop together at full
        send(901);
        send(902);
        send(903);
        front_check("pushpop_front");
        send(904);
        tick();
        m_tready = 1'b1;
        tick();
        m_tready = 1'b0;
        chk("pushpop_fill", 65'(fill), 65'd16);
        chk("pushpop_drop_cnt", 65'(drop_cnt), 65'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("clr_overflow", 65'(overflow), 65'd0);
        chk("clr_drop_cnt", 65'(drop_cnt), 65'd0);
        drain(16, "drain_order");
        chk("drained_fill", 65'(fill), 65'd0);
        chk("drained_valid", 65'(m_tvalid), 65'd0);
        // framing
        do_reset();
        chk("frame_rst_fill", 65'(fill), 65'd0);
        for (int i = 0; i < 32; i++) send(i * 37 - 500);
        drain(8, "frame");
        // reset mid-beat
        send(111);
        send(222);
        do_reset();
        send(5);
        send(6);
        send(7);
        send(8);
        drain(1, "post_rst_beat");
        repeat (5) tick();
        chk("post_rst_valid", 65'(m_tvalid), 65'd0);
        chk("post_rst_fill", 65'(fill), 65'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
